serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to load operands; sampled on rising clk.
REQ-005 a  input  WIDTH  minuend; unsigned or two's complement.
REQ-006 b  input  WIDTH  subtrahend.
REQ-007 bin  input  1  borrow-in.
REQ-008 busy  output  1  high while a subtraction is in progress.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-011 bout  output  1  final borrow-out; 1 when unsigned a < b + bin.
REQ-012 ovf  output  1  signed overflow of a - b - bin.

Function
REQ-013 Datapath: one full-subtractor bit per cycle, LSB first.
- d = x ^ y ^ br
- br_next = (~x & y) | (~(x ^ y) & br)
REQ-014 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-015 Transitions:
- IDLE -> SHIFT on start=1.
- SHIFT -> DONE after WIDTH bit cycles.
- DONE -> IDLE unconditionally after one cycle.
REQ-016 Load edge (start=1 in IDLE): capture a and b into shift registers, bin into the borrow register, clear the bit counter, set busy=1.
REQ-017 SHIFT: each edge processes one bit, shifts d into the result register from the MSB side, updates borrow and increments the counter.
REQ-018 Latency: with load at edge k, bit i is processed at edge k+1+i.
- At edge k+WIDTH: busy=0, done=1, diff/bout/ovf updated.
- At edge k+WIDTH+1: done=0.
REQ-019 ovf SHALL equal (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]) using the operands captured at load.
REQ-020 start is ignored in SHIFT and DONE; captured operands do not change and no restart occurs.
REQ-021 Changes on a, b or bin after the load edge SHALL NOT affect the result.
REQ-022 diff, bout and ovf SHALL hold their last values from the DONE edge until the next completion; they SHALL NOT change during SHIFT.
REQ-023 start=1 on the cycle done=1 is ignored; a new request is accepted from IDLE only.
- Minimum start-to-start spacing: WIDTH+2 cycles.
REQ-024 WIDTH=1: SHIFT lasts exactly one cycle; done rises at edge k+1.
REQ-025 Counter SHALL be sized ceil(log2(WIDTH+1)) bits and SHALL NOT wrap within an operation.

Reset
REQ-026 rst=1 SHALL immediately force, without waiting for clk:
- state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, counter=0, borrow register=0.
REQ-027 rst asserted mid-SHIFT aborts the operation; no done pulse is produced for it.
REQ-028 After rst deasserts, the first rising edge with start=1 SHALL be accepted as a load.

Verification
REQ-029 WIDTH=8: a=0x5A, b=0x23, bin=0, start for one cycle.
- busy high 8 cycles, then done pulse.
- diff=0x37, bout=0, ovf=0.
REQ-030 WIDTH=8: a=0x10, b=0x20, bin=1.
- diff=0xEF, bout=1, ovf=0.
REQ-031 WIDTH=8: a=0x80, b=0x01, bin=0.
- diff=0x7F, bout=0, ovf=1.
- Second case a=0x7F, b=0xFF: diff=0x80, bout=1, ovf=1.
REQ-032 Start is held high continuously while a and b change every cycle during SHIFT.
- Exactly one result, computed from the load-edge operands.
- Next load occurs in the cycle after DONE.
REQ-033 rst pulsed at bit 4 of an operation.
- All outputs zero immediately, no done pulse.
- A following request a=0xFF, b=0xFF, bin=0 yields diff=0x00, bout=0, ovf=0.
REQ-034 WIDTH=1: a=0, b=1, bin=0.
- done at edge k+1; diff=1, bout=1, ovf=1.

Source files
------------

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor. It computes diff = a - b - bin (modulo 2^WIDTH), one
// full-subtractor bit per clock cycle, starting with the LSB. It also reports
// the final borrow-out and the signed overflow of the operation.
//
// Parameters
//   WIDTH  operand/result width in bits (1..32)
//
// Ports
//   clk    clock; every state change happens on the rising edge
//   rst    asynchronous, active-high reset
//   start  load request; only accepted while idle
//   a      minuend (unsigned or two's complement)
//   b      subtrahend
//   bin    borrow-in
//   busy   high while the bit-serial operation is running
//   done   one-cycle pulse; diff/bout/ovf were updated on the same edge
//   diff   result a - b - bin, held until the next completion
//   bout   final borrow-out (unsigned a < b + bin)
//   ovf    signed overflow of a - b - bin
// ----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    // The counter must be able to hold the value WIDTH without wrapping.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;        // minuend shifter; also collects the result
    logic [WIDTH-1:0] b_q, b_d;        // subtrahend shifter
    logic             br_q, br_d;      // running borrow
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             x, y, d, br_next;
    logic [WIDTH-1:0] a_shift, b_shift;

    // One full-subtractor bit on the current LSBs.
    assign x       = a_q[0];
    assign y       = b_q[0];
    assign d       = x ^ y ^ br_q;
    assign br_next = (~x & y) | (~(x ^ y) & br_q);

    // The minuend shifter drains from the LSB while difference bits enter at
    // the MSB, so after WIDTH shifts it holds the complete result.
    generate
        if (WIDTH == 1) begin : g_w1
            assign a_shift = d;
            assign b_shift = 1'b0;
        end else begin : g_wn
            assign a_shift = {d, a_q[WIDTH-1:1]};
            assign b_shift = {1'b0, b_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    // Operand MSBs are kept aside because the shifters lose them.
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy  = 1'b1;
                a_d   = a_shift;
                b_d   = b_shift;
                br_d  = br_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Final bit: publish the result on this same edge.
                    state_d = DONE;
                    diff_d  = a_shift;
                    bout_d  = br_next;
                    ovf_d   = (a_msb_q != b_msb_q) & (d != a_msb_q);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule
